// File: rtl/pitch_tuner.sv
// Pitch selector: semitone up/down keys with hold-to-repeat, plus direct one-hot note and octave loads.
// Every output is registered; all logic runs on posedge dclk with synchronous active-high reset.
module pitch_tuner #(
   parameter int OCTAVES      = 5,
   parameter int OCT_W        = 3,
   parameter int REPEAT_DELAY = 8,
   parameter int REPEAT_RATE  = 4,
   parameter int WRAP         = 1,
   parameter int RST_NOTE     = 9,
   parameter int RST_OCT      = 2
) (
   input  logic               dclk,
   input  logic               rst,
   input  logic               high,
   input  logic               low,
   input  logic [12:0]        note_in,
   input  logic [OCTAVES-1:0] oct_in,
   output logic [3:0]         freq,
   output logic [OCT_W-1:0]   h,
   output logic               changed,
   output logic               repeating
);

   localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [3:0]       NOTE_C  = 4'd0;
   localparam logic [3:0]       NOTE_B  = 4'd11;
   localparam logic [3:0]       NOTE_X  = 4'd12;
   localparam logic [OCT_W-1:0] OCT_TOP = OCT_W'(OCTAVES - 1);
   localparam logic [OCT_W-1:0] OCT_ONE = OCT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DELAY  = 2'd1,
      S_REPEAT = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             dir_q, dir_d;
   logic [3:0]       freq_q, freq_d;
   logic [OCT_W-1:0] h_q, h_d;
   logic             changed_q, changed_d;
   logic             repeating_q, repeating_d;

   logic             key, key_up, same_key, do_step;
   logic [3:0]       step_note;
   logic [OCT_W-1:0] step_oct;
   logic             step_carry;
   logic             note_ok, oct_ok;
   logic [3:0]       note_idx;
   logic [OCT_W-1:0] oct_idx;

   // Both keys pressed cancels out to "no key".
   assign key      = high ^ low;
   assign key_up   = high & ~low;
   assign same_key = key && (key_up == dir_q);
   assign cnt_inc  = cnt_q + CNT_W'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      do_step = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (key) begin
               state_d = S_DELAY;
               cnt_d   = '0;
               dir_d   = key_up;
               do_step = 1'b1;
            end
         end
         S_DELAY: begin
            if (!same_key) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_inc == CNT_W'(REPEAT_DELAY - 1)) begin
               state_d = S_REPEAT;
               cnt_d   = '0;
               do_step = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_REPEAT: begin
            if (!same_key) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_inc == CNT_W'(REPEAT_RATE)) begin
               cnt_d   = '0;
               do_step = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Semitone step; a blocked saturating step leaves note and octave untouched.
   always_comb begin
      step_note  = freq_q;
      step_oct   = h_q;
      step_carry = 1'b0;
      if (key_up) begin
         if (freq_q == NOTE_X) begin
            step_note = NOTE_C;
         end else if (freq_q == NOTE_B) begin
            if (h_q != OCT_TOP) begin
               step_note  = NOTE_C;
               step_oct   = h_q + OCT_ONE;
               step_carry = 1'b1;
            end else if (WRAP != 0) begin
               step_note  = NOTE_C;
               step_oct   = '0;
               step_carry = 1'b1;
            end
         end else begin
            step_note = freq_q + 4'd1;
         end
      end else begin
         if (freq_q == NOTE_X) begin
            step_note = NOTE_B;
         end else if (freq_q == NOTE_C) begin
            if (h_q != '0) begin
               step_note  = NOTE_B;
               step_oct   = h_q - OCT_ONE;
               step_carry = 1'b1;
            end else if (WRAP != 0) begin
               step_note  = NOTE_B;
               step_oct   = OCT_TOP;
               step_carry = 1'b1;
            end
         end else begin
            step_note = freq_q - 4'd1;
         end
      end
   end

   always_comb begin
      note_ok  = (note_in != '0) && ((note_in & (note_in - 13'd1)) == '0);
      note_idx = '0;
      for (int k = 0; k < 13; k++) begin
         if (note_in[k]) note_idx = 4'(k);
      end
      oct_ok  = (oct_in != '0) && ((oct_in & (oct_in - OCTAVES'(1))) == '0);
      oct_idx = '0;
      // oct_in bit 0 selects the highest octave.
      for (int i = 0; i < OCTAVES; i++) begin
         if (oct_in[i]) oct_idx = OCT_W'(OCTAVES - 1 - i);
      end
   end

   always_comb begin
      freq_d = freq_q;
      h_d    = h_q;
      if (do_step) begin
         freq_d = step_note;
      end else if ((state_q == S_IDLE) && !key && note_ok) begin
         freq_d = note_idx;
      end
      if (do_step && step_carry) begin
         h_d = step_oct;
      end else if (oct_ok) begin
         h_d = oct_idx;
      end
      changed_d   = (freq_d != freq_q) || (h_d != h_q);
      repeating_d = (state_d == S_REPEAT);
   end

   always_ff @(posedge dclk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         dir_q       <= 1'b0;
         freq_q      <= 4'(RST_NOTE);
         h_q         <= OCT_W'(RST_OCT);
         changed_q   <= 1'b0;
         repeating_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dir_q       <= dir_d;
         freq_q      <= freq_d;
         h_q         <= h_d;
         changed_q   <= changed_d;
         repeating_q <= repeating_d;
      end
   end

   assign freq      = freq_q;
   assign h         = h_q;
   assign changed   = changed_q;
   assign repeating = repeating_q;

endmodule

// File: tb/tb_pitch_tuner.sv
// Bench for pitch_tuner: a wrapping and a saturating instance share stimulus and are
// compared every cycle against a pitch-number model, plus directed scenario checks.
module tb_pitch_tuner;

   localparam int OCTAVES = 5;
   localparam int RD      = 8;
   localparam int RATE    = 4;
   localparam int TOP_P   = OCTAVES * 12 - 1;

   logic        dclk;
   logic        rst, high, low;
   logic [12:0] note_in;
   logic [4:0]  oct_in;
   logic [3:0]  freq_w, freq_s;
   logic [2:0]  h_w, h_s;
   logic        chg_w, chg_s, rep_w, rep_s;

   int errors = 0;
   int checks = 0;

   // Expected {freq, h, changed, repeating} per instance, pushed by the model each cycle.
   logic [8:0] exp_q[$];

   int m_freq[2];
   int m_h[2];
   int m_chg[2];
   int m_n;
   int m_dir;
   int m_rep;

   pitch_tuner #(.WRAP(1)) u_wrap (
      .dclk(dclk), .rst(rst), .high(high), .low(low), .note_in(note_in), .oct_in(oct_in),
      .freq(freq_w), .h(h_w), .changed(chg_w), .repeating(rep_w)
   );

   pitch_tuner #(.WRAP(0)) u_sat (
      .dclk(dclk), .rst(rst), .high(high), .low(low), .note_in(note_in), .oct_in(oct_in),
      .freq(freq_s), .h(h_s), .changed(chg_s), .repeating(rep_s)
   );

   initial begin
      dclk = 1'b0;
      forever #5 dclk = ~dclk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int bit_index(input logic [31:0] v);
      int idx = 0;
      for (int i = 0; i < 32; i++) if (v[i]) idx = i;
      return idx;
   endfunction

   // Model: key hold length decides steps; pitch is octave*12+note on a linear scale.
   task automatic model_step();
      int was_idle, kp, stepping, nf, nh, p;
      if (rst) begin
         m_n = -1; m_dir = 0; m_rep = 0;
         for (int d = 0; d < 2; d++) begin
            m_freq[d] = 9; m_h[d] = 2; m_chg[d] = 0;
            exp_q.push_back({4'(m_freq[d]), 3'(m_h[d]), 1'b0, 1'b0});
         end
         return;
      end
      was_idle = (m_n < 0);
      kp       = high ^ low;
      stepping = 0;
      if (!kp) m_n = -1;
      else if (m_n < 0) begin
         m_n = 0; m_dir = high; stepping = 1;
      end else if (int'(high) != m_dir) m_n = -1;
      else begin
         m_n++;
         if (m_n == RD - 1) stepping = 1;
         else if (m_n > RD - 1 && ((m_n - (RD - 1)) % RATE) == 0) stepping = 1;
      end
      m_rep = (m_n >= RD - 1);
      for (int d = 0; d < 2; d++) begin
         int carry = 0;
         nf = m_freq[d];
         nh = m_h[d];
         if (stepping) begin
            if (m_freq[d] == 12) nf = high ? 0 : 11;
            else begin
               p = m_h[d] * 12 + m_freq[d];
               if (high) p = (p == TOP_P) ? ((d == 0) ? 0 : p) : p + 1;
               else      p = (p == 0) ? ((d == 0) ? TOP_P : 0) : p - 1;
               nf = p % 12;
               nh = p / 12;
               carry = (nh != m_h[d]);
            end
         end else if (was_idle && !kp && $countones(note_in) == 1) begin
            nf = bit_index(32'(note_in));
         end
         if (!carry && $countones(oct_in) == 1) nh = OCTAVES - 1 - bit_index(32'(oct_in));
         m_chg[d]  = (nf != m_freq[d]) || (nh != m_h[d]);
         m_freq[d] = nf;
         m_h[d]    = nh;
         exp_q.push_back({4'(nf), 3'(nh), 1'(m_chg[d]), 1'(m_rep)});
      end
   endtask

   task automatic check_all();
      logic [8:0] e;
      logic [8:0] obs[2];
      string      nm[2];
      obs[0] = {freq_w, h_w, chg_w, rep_w};
      obs[1] = {freq_s, h_s, chg_s, rep_s};
      nm[0]  = "wrap";
      nm[1]  = "sat";
      for (int d = 0; d < 2; d++) begin
         e = exp_q.pop_front();
         chk({nm[d], ".freq"},      32'(obs[d][8:5]), 32'(e[8:5]));
         chk({nm[d], ".h"},         32'(obs[d][4:2]), 32'(e[4:2]));
         chk({nm[d], ".changed"},   32'(obs[d][1]),   32'(e[1]));
         chk({nm[d], ".repeating"}, 32'(obs[d][0]),   32'(e[0]));
      end
   endtask

   task automatic tick(input logic r, input logic hi, input logic lo,
                       input logic [12:0] nt, input logic [4:0] oc);
      rst = r; high = hi; low = lo; note_in = nt; oct_in = oc;
      @(posedge dclk);
      model_step();
      #1;
      check_all();
   endtask

   initial begin
      int ksel;
      logic hi_r, lo_r;
      logic [12:0] nt_r;
      logic [4:0]  oc_r;

      rst = 1'b1; high = 1'b0; low = 1'b0; note_in = '0; oct_in = '0;

      // Reset state
      tick(1, 0, 0, 0, 0);
      tick(1, 0, 0, 0, 0);
      chk("reset.freq", 32'(freq_w), 9);
      chk("reset.h", 32'(h_w), 2);
      chk("reset.changed", 32'(chg_w), 0);
      chk("reset.repeating", 32'(rep_w), 0);

      // Single up press from A/2
      tick(0, 1, 0, 0, 0);
      chk("single.freq", 32'(freq_w), 10);
      chk("single.h", 32'(h_w), 2);
      chk("single.changed", 32'(chg_w), 1);
      tick(0, 0, 0, 0, 0);
      chk("single.changed_end", 32'(chg_w), 0);
      chk("single.repeating", 32'(rep_w), 0);

      // Held key: steps at cycles 0, 7, 11, 15, 19
      tick(1, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) begin
         tick(0, 1, 0, 0, 0);
         if (i == 6) chk("hold.rep_before", 32'(rep_w), 0);
         if (i == 7) chk("hold.rep_after", 32'(rep_w), 1);
      end
      chk("hold.freq", 32'(freq_w), 2);
      chk("hold.h", 32'(h_w), 3);
      tick(0, 0, 0, 0, 0);

      // Range ends: wrap versus saturate
      tick(0, 0, 0, 13'h0800, 5'b00001);
      tick(0, 1, 0, 0, 0);
      chk("wrap_up.freq", 32'(freq_w), 0);
      chk("wrap_up.h", 32'(h_w), 0);
      chk("sat_up.freq", 32'(freq_s), 11);
      chk("sat_up.h", 32'(h_s), 4);
      chk("sat_up.changed", 32'(chg_s), 0);
      tick(0, 0, 0, 0, 0);
      tick(0, 0, 0, 13'h0001, 5'b10000);
      tick(0, 0, 1, 0, 0);
      chk("wrap_dn.freq", 32'(freq_w), 11);
      chk("wrap_dn.h", 32'(h_w), 4);
      chk("sat_dn.freq", 32'(freq_s), 0);
      chk("sat_dn.h", 32'(h_s), 0);
      tick(0, 0, 0, 0, 0);

      // Direct note loads
      tick(0, 0, 0, 13'h0400, 0);
      chk("note.load10", 32'(freq_w), 10);
      tick(0, 0, 0, 13'h0003, 0);
      chk("note.multihot", 32'(freq_w), 10);
      tick(0, 0, 0, 13'h1000, 0);
      chk("note.rest", 32'(freq_w), 12);
      tick(0, 0, 1, 0, 0);
      chk("note.rest_dn", 32'(freq_w), 11);
      chk("note.rest_dn_h", 32'(h_w), 4);
      tick(0, 0, 0, 0, 0);

      // Both keys held; then carry beats oct_in
      tick(1, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) tick(0, 1, 1, 0, 0);
      chk("both.freq", 32'(freq_w), 9);
      chk("both.repeating", 32'(rep_w), 0);
      tick(0, 0, 0, 13'h0800, 5'b01000);
      tick(0, 1, 0, 0, 5'b00001);
      chk("carry.freq", 32'(freq_w), 0);
      chk("carry.h", 32'(h_w), 2);
      tick(0, 0, 0, 0, 0);

      // Reset during repeat with key still held
      tick(1, 0, 0, 0, 0);
      for (int i = 0; i < 12; i++) tick(0, 1, 0, 0, 0);
      chk("rstrep.repeating_pre", 32'(rep_w), 1);
      tick(1, 1, 0, 0, 0);
      chk("rstrep.freq", 32'(freq_w), 9);
      chk("rstrep.h", 32'(h_w), 2);
      chk("rstrep.repeating", 32'(rep_w), 0);
      tick(0, 1, 0, 0, 0);
      chk("rstrep.fresh", 32'(freq_w), 10);
      tick(0, 0, 0, 0, 0);

      // Randomized traffic
      ksel = 0;
      for (int c = 0; c < 600; c++) begin
         int nsel, osel;
         if ($urandom_range(0, 11) == 0) ksel = $urandom_range(0, 3);
         hi_r = (ksel == 1) || (ksel == 3);
         lo_r = (ksel == 2) || (ksel == 3);
         nsel = $urandom_range(0, 9);
         nt_r = '0;
         if (nsel == 6 || nsel == 7) nt_r = 13'(1) << $urandom_range(0, 12);
         else if (nsel == 8) nt_r = 13'($urandom);
         osel = $urandom_range(0, 9);
         oc_r = '0;
         if (osel == 6) oc_r = 5'(1) << $urandom_range(0, 4);
         else if (osel == 7) oc_r = 5'($urandom);
         tick($urandom_range(0, 99) == 0, hi_r, lo_r, nt_r, oc_r);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pitch_tuner.md
PITCH_TUNER -- requirements
Module: pitch_tuner

Interface
REQ-001 SHALL have parameter OCTAVES, default 5, number of selectable octaves (2..8).
REQ-002 SHALL have parameter OCT_W, default 3, octave index width, with OCT_W >= clog2(OCTAVES).
REQ-003 SHALL have parameter REPEAT_DELAY, default 8, hold cycles before auto-repeat starts (>= 2).
REQ-004 SHALL have parameter REPEAT_RATE, default 4, cycles between auto-repeat steps (>= 1).
REQ-005 SHALL have parameter WRAP, default 1; 1 = octave wraps at range ends, 0 = saturates.
REQ-006 SHALL have parameter RST_NOTE, default 9 (A), reset note code.
REQ-007 SHALL have parameter RST_OCT, default 2, reset octave index.
REQ-008 SHALL have port dclk, input, 1 bit: the only clock; all logic rises on posedge dclk.
REQ-009 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-010 SHALL have port high, input, 1 bit: semitone-up key (level).
REQ-011 SHALL have port low, input, 1 bit: semitone-down key (level).
REQ-012 SHALL have port note_in, input, 13 bits: one-hot direct note select; bit k = note k (0=C..11=B); bit 12 = rest X.
REQ-013 SHALL have port oct_in, input, OCTAVES bits: one-hot octave select; bit 0 = highest octave OCTAVES-1, bit OCTAVES-1 = octave 0.
REQ-014 SHALL have port freq, output, 4 bits, registered: note code 0..11, or 12 = rest.
REQ-015 SHALL have port h, output, OCT_W bits, registered: octave index 0..OCTAVES-1.
REQ-016 SHALL have port changed, output, 1 bit, registered: one-cycle pulse whenever freq or h took a new value.
REQ-017 SHALL have port repeating, output, 1 bit, registered: high while the key FSM is in REPEAT.

Function
REQ-018 Key FSM SHALL have states IDLE, DELAY, REPEAT; key = high XOR low; both-pressed and none-pressed both count as no key.
REQ-019 IDLE SHALL go to DELAY on key and issue one step in the same cycle; the counter SHALL load 0.
REQ-020 DELAY SHALL count each cycle the same key stays held; at count REPEAT_DELAY-1 it SHALL step, go to REPEAT, and clear the counter.
REQ-021 REPEAT SHALL step once every REPEAT_RATE cycles while the same key stays held.
REQ-022 Key release, both keys pressed, or a change of key direction SHALL return the FSM to IDLE with no step that cycle; a new direction SHALL step from IDLE on the next cycle.
REQ-023 Up step SHALL do: note n<11 -> n+1; B -> C with octave +1; X -> C with octave unchanged.
REQ-024 Down step SHALL do: note n>0 -> n-1; C -> B with octave -1; X -> B with octave unchanged.
REQ-025 Octave carry past OCTAVES-1 or below 0 SHALL wrap (to 0 / to OCTAVES-1) when WRAP=1.
REQ-026 With WRAP=0, a step at B in the top octave, or at C in octave 0, SHALL leave freq and h unchanged.
REQ-027 When the FSM is IDLE and no key is pressed, a one-hot note_in SHALL load freq; zero or multi-hot note_in SHALL be ignored.
REQ-028 A valid one-hot oct_in SHALL load h in any state unless the same cycle carries an octave change, in which case the carry wins; invalid oct_in SHALL be ignored.
REQ-029 Latency SHALL be 1 cycle: an input sampled at edge N is reflected in freq/h after edge N.
REQ-030 changed SHALL be asserted in the cycle after an edge where {freq,h} differed from its previous value; it SHALL not assert when a load writes an identical value.
REQ-031 freq SHALL never hold 13..15, and h SHALL never exceed OCTAVES-1.

Reset
REQ-032 While rst is high at an edge, freq SHALL become RST_NOTE, h SHALL become RST_OCT, FSM SHALL go to IDLE, counter SHALL be 0, and changed and repeating SHALL be 0.
REQ-033 rst SHALL override all inputs, including a held key mid-repeat; after release, a still-held key SHALL be treated as a fresh press (step on the first cycle).

Verification
REQ-034 Defaults; reset, then high held 1 cycle -> freq 9->10, h=2, changed pulses once, repeating=0.
REQ-035 Defaults; high held 20 cycles from A/2 -> steps at cycles 0, 7, 11, 15, 19 -> final freq=2 (D), h=3; repeating high from cycle 7 on.
REQ-036 WRAP=1; start at B/4, pulse high -> C/0. WRAP=0; same stimulus -> B/4 unchanged with no changed pulse. Start at C/0, pulse low -> B/4 with WRAP=1.
REQ-037 note_in=13'h0400 with no key -> freq=10; note_in=13'h0003 -> freq unchanged; note_in=13'h1000 -> freq=12; then pulse low -> freq=11, h unchanged.
REQ-038 high and low held together for 10 cycles -> no steps and FSM IDLE; at B/1, high plus oct_in=5'b00001 in the same cycle -> C/2 (carry wins).
REQ-039 rst asserted for 1 cycle during REPEAT with high still held -> A/2 after reset; on the first post-reset cycle, freq becomes 10.
